hilo_muldiv: RTL

HILO_MULDIV -- requirements
Module: hilo_muldiv

---
 rtl/hilo_muldiv.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/hilo_muldiv.sv
// HI/LO multiply-divide unit.
// Performs 32x32 multiply (signed/unsigned) and 32/32 divide (signed/unsigned)
// iteratively, one bit per cycle, and holds the results in the HI/LO registers.
// mthi/mtlo load HI/LO directly while the unit is idle.
module hilo_muldiv (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        mthi,
  input  logic        mtlo,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero,
  output logic [31:0] hi_reg,
  output logic [31:0] lo_reg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIN  = 2'd3
  } state_e;

  state_e      state_q;
  logic [5:0]  cnt_q;
  logic [63:0] acc_q;      // mul: {partial product, multiplier}; div: {remainder, dividend/quotient}
  logic [31:0] opb_q;      // multiplicand (mul) or divisor (div) magnitude
  logic        is_div_q;
  logic        neg_q;      // negate product / quotient at FIN
  logic        rem_neg_q;  // negate remainder at FIN
  logic        busy_q;
  logic        done_q;
  logic        dbz_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  logic        signed_op;
  logic [31:0] rs_abs;
  logic [31:0] rt_abs;
  logic [32:0] mul_sum_d;
  logic [63:0] mul_acc_d;
  logic [32:0] div_trial_d;
  logic [63:0] div_acc_d;
  logic [63:0] mul_res_d;
  logic [31:0] quo_res_d;
  logic [31:0] rem_res_d;

  // Operand magnitudes, iteration steps and sign-corrected final results.
  // NOTE: every output of this block is assigned on every path, so no latch can form.
  always_comb begin
    signed_op   = ~op[0];
    rs_abs      = (signed_op && rs_val[31]) ? (32'd0 - rs_val) : rs_val;
    rt_abs      = (signed_op && rt_val[31]) ? (32'd0 - rt_val) : rt_val;

    // Shift-add: conditionally add the multiplicand to the upper half, then shift right.
    mul_sum_d   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
    mul_acc_d   = {mul_sum_d, acc_q[31:1]};

    // Restoring divide: shift the next dividend bit into the remainder and try a subtract.
    div_trial_d = {acc_q[63:32], acc_q[31]} - {1'b0, opb_q};
    div_acc_d   = div_trial_d[32] ? {acc_q[62:0], 1'b0}
                                  : {div_trial_d[31:0], acc_q[30:0], 1'b1};

    mul_res_d   = neg_q     ? (64'd0 - acc_q)         : acc_q;
    quo_res_d   = neg_q     ? (32'd0 - acc_q[31:0])   : acc_q[31:0];
    rem_res_d   = rem_neg_q ? (32'd0 - acc_q[63:32])  : acc_q[63:32];
  end

  // Control FSM together with the datapath and HI/LO result registers.
  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: datapath registers are reset too, so an aborted operation leaves nothing behind.
      state_q   <= S_IDLE;
      cnt_q     <= 6'd0;
      acc_q     <= 64'd0;
      opb_q     <= 32'd0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            cnt_q     <= 6'd0;
            is_div_q  <= op[1];
            neg_q     <= signed_op & (rs_val[31] ^ rt_val[31]);
            rem_neg_q <= signed_op & rs_val[31];
            busy_q    <= 1'b1;
            if (op[1]) begin
              acc_q   <= {32'd0, rs_abs};
              opb_q   <= rt_abs;
              state_q <= S_DIV;
            end else begin
              acc_q   <= {32'd0, rt_abs};
              opb_q   <= rs_abs;
              state_q <= S_MUL;
            end
          end else begin
            if (mthi) hi_q <= rs_val;
            if (mtlo) lo_q <= rs_val;
          end
        end
        S_MUL: begin
          acc_q <= mul_acc_d;
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == 6'd31) state_q <= S_FIN;
        end
        S_DIV: begin
          if (opb_q == 32'd0) begin
            // Divide by zero completes straight away; HI/LO keep their values.
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            dbz_q   <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            acc_q <= div_acc_d;
            cnt_q <= cnt_q + 6'd1;
            if (cnt_q == 6'd31) state_q <= S_FIN;
          end
        end
        S_FIN: begin
          if (is_div_q) begin
            hi_q <= rem_res_d;
            lo_q <= quo_res_d;
          end else begin
            hi_q <= mul_res_d[63:32];
            lo_q <= mul_res_d[31:0];
          end
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi_reg      = hi_q;
  assign lo_reg      = lo_q;

endmodule
